// File: rtl/exmem_stage_buf.sv
// EX->MEM pipeline register with a 2-entry skid buffer; optional stall counter under `EXMEM_STALL_CNT_EN`.
// Latency: 1 cycle from accept to out_valid; throughput 1 bundle/cycle while out_ready=1.
// Backpressure: in_ready decodes registered state only, so there is no combinational path from out_ready.
module exmem_stage_buf #(
    parameter int S = 15,
    parameter int B = 7,
    parameter int C = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [S:0]   in_upper,
    input  logic [S:0]   in_lower,
    input  logic [S:0]   in_word,
    input  logic [B:0]   in_byte,
    input  logic [C:0]   in_ctrl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [S:0]   out_upper,
    output logic [S:0]   out_lower,
    output logic [S:0]   out_word,
    output logic [B:0]   out_byte,
    output logic [C:0]   out_ctrl
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);

    typedef struct packed {
        logic [S:0] upper;
        logic [S:0] lower;
        logic [S:0] word;
        logic [B:0] byte_v;
        logic [C:0] ctrl;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t  r_state;
    state_t  w_state_nxt;
    bundle_t r_main;
    bundle_t r_skid;
    bundle_t w_in;
    logic    w_accept;
    logic    w_fire;
    logic    w_main_from_in;
    logic    w_main_from_skid;
    logic    w_skid_from_in;

    assign w_in      = '{upper: in_upper, lower: in_lower, word: in_word,
                         byte_v: in_byte, ctrl: in_ctrl};
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_fire    = out_valid & out_ready;

    assign out_upper = r_main.upper;
    assign out_lower = r_main.lower;
    assign out_word  = r_main.word;
    assign out_byte  = r_main.byte_v;
    // A bubble must never present stale read/write enables to MEM.
    assign out_ctrl  = out_valid ? r_main.ctrl : '0;

    // Next-state and register-load decode; flush overrides to EMPTY.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_main_from_in = 1'b1;
                    w_state_nxt    = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_fire) begin
                    w_main_from_in = 1'b1;
                end else if (w_accept) begin
                    w_skid_from_in = 1'b1;
                    w_state_nxt    = FULL;
                end else if (w_fire) begin
                    w_state_nxt    = EMPTY;
                end
            end
            FULL: begin
                if (w_fire) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ONE;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_main_from_in   = 1'b0;
            w_main_from_skid = 1'b0;
            w_skid_from_in   = 1'b0;
        end
    end

    // State register and main/skid data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_main_from_in) begin
                r_main <= w_in;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= w_in;
            end
        end
    end

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    assign stall_cnt = r_stall_cnt;

    // Saturating count of cycles where MEM holds off a valid bundle; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exmem_stage_buf.sv
// Directed bench for exmem_stage_buf: reset, streaming, backpressure, flush, bubble ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point as well.
// Optional stall counter checks are compiled in when EXMEM_STALL_CNT_EN is defined.
module tb_exmem_stage_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_upper;
    logic [15:0] in_lower;
    logic [15:0] in_word;
    logic [7:0]  in_byte;
    logic [1:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_upper;
    logic [15:0] out_lower;
    logic [15:0] out_word;
    logic [7:0]  out_byte;
    logic [1:0]  out_ctrl;
`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    exmem_stage_buf #(.S(15), .B(7), .C(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_upper  (in_upper),
        .in_lower  (in_lower),
        .in_word   (in_word),
        .in_byte   (in_byte),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_upper (out_upper),
        .out_lower (out_lower),
        .out_word  (out_word),
        .out_byte  (out_byte),
        .out_ctrl  (out_ctrl)
`ifdef EXMEM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] w, input logic [1:0] c);
        in_valid = v;
        in_word  = w;
        in_upper = ~w;
        in_lower = {w[7:0], w[15:8]};
        in_byte  = w[7:0] ^ 8'h5A;
        in_ctrl  = c;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 16'h5555, 2'b11);

        // Reset held two cycles while EX offers data
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_upper", out_upper, 0);
        rst = 1'b0;
        drive(1'b0, 16'h0, 2'b00);
        tick();
        chk("rst_no_accept", out_valid, 0);

        // Streaming with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 2'b01);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_word", out_word, 32'(i));
            chk("stream_in_ready", in_ready, 1);
        end
        chk("stream_upper", out_upper, 32'(16'hFFF7));
        chk("stream_lower", out_lower, 32'h0800);
        chk("stream_byte", out_byte, 32'h52);
        chk("stream_ctrl", out_ctrl, 1);
        drive(1'b0, 16'h0, 2'b00);
        tick();
        chk("stream_drain", out_valid, 0);

        // Backpressure: two entries fit, the third is held off
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 2'b01);
        tick();
        chk("bp_a_word", out_word, 32'hAAAA);
        chk("bp_a_in_ready", in_ready, 1);
        drive(1'b1, 16'hBBBB, 2'b01);
        tick();
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_full_word", out_word, 32'hAAAA);
        drive(1'b1, 16'hCCCC, 2'b01);
        tick();
        chk("bp_held_in_ready", in_ready, 0);
        chk("bp_held_word", out_word, 32'hAAAA);
        out_ready = 1'b1;
        #1;
        chk("bp_out0", out_word, 32'hAAAA);
        tick();
        chk("bp_out1", out_word, 32'hBBBB);
        chk("bp_out1_in_ready", in_ready, 1);
        tick();
        chk("bp_out2", out_word, 32'hCCCC);
        drive(1'b0, 16'h0, 2'b00);
        tick();
        chk("bp_drain", out_valid, 0);

        // Flush from FULL with a valid input in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 2'b11);
        tick();
        drive(1'b1, 16'h2222, 2'b11);
        tick();
        chk("fl_full", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 16'h3333, 2'b11);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 2'b00);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_out_ctrl", out_ctrl, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("fl_no_3333", out_valid, 0);

        // Flush from ONE while in_ready=1: the offered bundle is dropped too
        out_ready = 1'b0;
        drive(1'b1, 16'h4444, 2'b10);
        tick();
        flush = 1'b1;
        drive(1'b1, 16'h3333, 2'b11);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 2'b00);
        chk("fl1_out_valid", out_valid, 0);
        tick();
        chk("fl1_still_empty", out_valid, 0);

        // Bubble ctrl: ctrl visible while valid, zero once consumed
        drive(1'b1, 16'h7777, 2'b11);
        tick();
        drive(1'b0, 16'h0, 2'b00);
        chk("bub_ctrl_valid", out_ctrl, 3);
        tick();
        chk("bub_ctrl_stall", out_ctrl, 3);
        out_ready = 1'b1;
        tick();
        chk("bub_valid_off", out_valid, 0);
        chk("bub_ctrl_zero", out_ctrl, 0);
        chk("bub_word_kept", out_word, 32'h7777);

`ifdef EXMEM_STALL_CNT_EN
        // Stall counter: five held cycles, then reset clears it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sc_after_rst", stall_cnt, 0);
        out_ready = 1'b0;
        drive(1'b1, 16'h9999, 2'b01);
        tick();
        drive(1'b0, 16'h0, 2'b00);
        for (int k = 0; k < 5; k++) tick();
        chk("sc_five", stall_cnt, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sc_flush_keeps", stall_cnt, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sc_rst_clear", stall_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
